// File: rtl/syncfifo_param_if.sv
// Handshake/status bundle between syncfifo_param and its producer/consumer.
// master = the block driving requests; slave = the FIFO itself.
interface syncfifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  write_en;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  flush;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_en, read_en, data_in, flush, clr_err,
        input  out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  write_en, read_en, data_in, flush, clr_err,
        output out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/syncfifo_param.sv
// Parametrised single-clock FIFO with occupancy, almost flags, sticky errors and flush.
// Define SYNCFIFO_FWFT_EN for first-word-fall-through output; default is registered out.
module syncfifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input logic            clk,
    input logic            reset,
    syncfifo_param_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t AF_P    = ptr_t'(AF_THRESH);
    localparam ptr_t AE_P    = ptr_t'(AE_THRESH);

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } flags_t;

    localparam flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    ptr_t   count_q,  count_d;
    flags_t flags_q,  flags_d;
    logic   ovf_q,    ovf_d;
    logic   udf_q,    udf_d;
    logic   wr_acc;
    logic   rd_acc;

    // Acceptance looks only at the registered flags, so it never depends on this cycle's update.
    always_comb begin
        wr_acc = bus.write_en && !flags_q.full  && !bus.flush;
        rd_acc = bus.read_en  && !flags_q.empty && !bus.flush;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a variable unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (bus.clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            // Set after the clear so a fresh error in the clr_err cycle survives.
            if (bus.write_en && flags_q.full)  ovf_d = 1'b1;
            if (bus.read_en  && flags_q.empty) udf_d = 1'b1;
        end

        flags_d.full         = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                               (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
        flags_d.empty        = (wr_ptr_d == rd_ptr_d);
        flags_d.almost_full  = (count_d >= AF_P);
        flags_d.almost_empty = (count_d <= AE_P);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= FLAGS_RST;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // NOTE: the storage array has no reset; pointers and flags alone define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[addr_t'(wr_ptr_q[ADDR_W-1:0])] <= bus.data_in;
        end
    end

`ifdef SYNCFIFO_FWFT_EN
    // Head entry falls through; forced to zero while nothing valid is stored.
    assign bus.out = flags_q.empty ? '0 : mem_q[addr_t'(rd_ptr_q[ADDR_W-1:0])];
`else
    logic [DATA_WIDTH-1:0] out_q, out_d;

    always_comb begin
        out_d = out_q;
        if (rd_acc) out_d = mem_q[addr_t'(rd_ptr_q[ADDR_W-1:0])];
    end

    always_ff @(posedge clk) begin
        if (reset) out_q <= '0;
        else       out_q <= out_d;
    end

    assign bus.out = out_q;
`endif

    assign bus.full         = flags_q.full;
    assign bus.empty        = flags_q.empty;
    assign bus.almost_full  = flags_q.almost_full;
    assign bus.almost_empty = flags_q.almost_empty;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

    // Pointer-derived flags must always agree with the occupancy counter.
    a_full_cnt:  assert property (@(posedge clk) disable iff (reset) flags_q.full  == (count_q == DEPTH_P));
    a_empty_cnt: assert property (@(posedge clk) disable iff (reset) flags_q.empty == (count_q == '0));
endmodule

// File: tb/tb_syncfifo_param.sv
// Directed bench for syncfifo_param: status checks inline, read data via a scoreboard queue and monitor.
module tb_syncfifo_param;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;

    syncfifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    syncfifo_param #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (6),
        .AE_THRESH (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;
    logic        rd_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_out(input logic [DW-1:0] act);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errs++;
            $display("FAIL read_data: unexpected read returned 0x%0h, nothing expected (t=%0t)", act, $time);
        end else begin
            mon_exp = exp_q.pop_front();
            if (act !== mon_exp) begin
                n_errs++;
                $display("FAIL read_data: got 0x%0h, expected 0x%0h (t=%0t)", act, mon_exp, $time);
            end
        end
    endtask

`ifdef SYNCFIFO_FWFT_EN
    // Head is on out while a pop is being requested.
    always @(posedge clk) begin
        if (bus.read_en && !bus.empty && !reset && !bus.flush) compare_out(bus.out);
    end
`else
    // Registered mode: data for an accepted read appears after the edge.
    always @(posedge clk) rd_pend = bus.read_en && !bus.empty && !reset && !bus.flush;
    always @(negedge clk) begin
        if (rd_pend) compare_out(bus.out);
    end
`endif

    task automatic step(input logic we, input logic re, input logic [DW-1:0] din,
                        input logic fl, input logic ce);
        bus.write_en = we;
        bus.read_en  = re;
        bus.data_in  = din;
        bus.flush    = fl;
        bus.clr_err  = ce;
        @(posedge clk);
        @(negedge clk);
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        bus.flush    = 1'b0;
        bus.clr_err  = 1'b0;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        step(1'b1, 1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic rd_expect(input logic [DW-1:0] d);
        exp_q.push_back(d);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"},  bus.empty,        1);
        check({tag, "_full"},   bus.full,         0);
        check({tag, "_count"},  bus.count,        0);
        check({tag, "_out"},    bus.out,          0);
        check({tag, "_ae"},     bus.almost_empty, 1);
        check({tag, "_af"},     bus.almost_full,  0);
        check({tag, "_ovf"},    bus.overflow,     0);
        check({tag, "_udf"},    bus.underflow,    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        bus.data_in  = '0;
        bus.flush    = 1'b0;
        bus.clr_err  = 1'b0;

        // 1: reset held two cycles
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b0;
        check_reset_state("rst");

        // 2: fill A0..A7, threshold crossings, overflow on 9th write
        for (int k = 0; k < 8; k++) begin
            wr(8'hA0 + 8'(k));
            check("fill_count", bus.count,        k + 1);
            check("fill_ae",    bus.almost_empty, (k + 1) <= 1);
            check("fill_af",    bus.almost_full,  (k + 1) >= 6);
            check("fill_full",  bus.full,         (k + 1) == 8);
            check("fill_empty", bus.empty,        0);
        end
        wr(8'hFF);
        check("ovf_full",  bus.full,      1);
        check("ovf_count", bus.count,     8);
        check("ovf_flag",  bus.overflow,  1);
        check("ovf_udf",   bus.underflow, 0);

        // 3: drain in order, underflow on 9th read
        for (int k = 0; k < 8; k++) begin
            rd_expect(8'hA0 + 8'(k));
            check("drain_count", bus.count, 7 - k);
            check("drain_empty", bus.empty, k == 7);
            check("drain_full",  bus.full,  0);
        end
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("udf_flag",   bus.underflow, 1);
        check("udf_count",  bus.count,     0);
        check("udf_ovf_sticky", bus.overflow, 1);
`ifdef SYNCFIFO_FWFT_EN
        check("udf_out", bus.out, 8'h00);
`else
        check("udf_out_hold", bus.out, 8'hA7);
`endif
        // clr_err with a new underflow in the same cycle: the new error wins
        step(1'b0, 1'b1, '0, 1'b0, 1'b1);
        check("clr_ovf",     bus.overflow,  0);
        check("clr_udf_win", bus.underflow, 1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("clr_udf", bus.underflow, 0);

        // 4: prefill 4, 12 cycles of simultaneous write+read, ptrs wrap
        for (int k = 0; k < 4; k++) wr(8'hB0 + 8'(k));
        check("pre_count", bus.count, 4);
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(i < 4 ? 8'hB0 + 8'(i) : 8'hC0 + 8'(i - 4));
            step(1'b1, 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
            check("rw_count", bus.count, 4);
        end
        for (int k = 0; k < 4; k++) rd_expect(8'hC8 + 8'(k));
        check("rw_empty", bus.empty, 1);

        // full + write + read: read taken, write dropped, overflow
        for (int k = 0; k < 8; k++) wr(8'hD0 + 8'(k));
        check("corner_full", bus.full, 1);
        exp_q.push_back(8'hD0);
        step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        check("fullrw_count", bus.count,    7);
        check("fullrw_ovf",   bus.overflow, 1);
        check("fullrw_full",  bus.full,     0);
        for (int k = 1; k < 8; k++) rd_expect(8'hD0 + 8'(k));
        check("fullrw_empty", bus.empty,     1);
        check("fullrw_udf",   bus.underflow, 0);

        // empty + write + read: write taken, read ignored, underflow
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        check("emptyrw_count", bus.count,     1);
        check("emptyrw_udf",   bus.underflow, 1);
        check("emptyrw_empty", bus.empty,     0);
        rd_expect(8'h77);
        check("emptyrw_drain", bus.count, 0);

        // 5: clear errors, flush at count=5 with write_en
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("clr2_ovf", bus.overflow,  0);
        check("clr2_udf", bus.underflow, 0);
        for (int k = 0; k < 5; k++) wr(8'hE0 + 8'(k));
        check("preflush_count", bus.count, 5);
        step(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
        check("flush_count", bus.count,    0);
        check("flush_empty", bus.empty,    1);
        check("flush_ae",    bus.almost_empty, 1);
        check("flush_ovf",   bus.overflow, 0);
        check("flush_udf",   bus.underflow, 0);
`ifdef SYNCFIFO_FWFT_EN
        check("flush_out", bus.out, 8'h00);
`else
        check("flush_out_hold", bus.out, 8'h77);
`endif
        wr(8'hF0);
        rd_expect(8'hF0);
        check("postflush_count", bus.count, 0);

        // 6: reset mid-stream at count=3 with an error pending
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("pre6_udf", bus.underflow, 1);
        for (int k = 0; k < 3; k++) wr(8'h31 + 8'(k));
        check("pre6_count", bus.count, 3);
        bus.write_en = 1'b1;
        bus.data_in  = 8'h34;
        reset        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset        = 1'b0;
        bus.write_en = 1'b0;
        check_reset_state("midrst");

        step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        check("w5a_empty", bus.empty, 0);
        check("w5a_count", bus.count, 1);
`ifdef SYNCFIFO_FWFT_EN
        check("w5a_out_fwft", bus.out, 8'h5A);
`else
        check("w5a_out_latency", bus.out, 8'h00);
`endif
        rd_expect(8'h5A);
        check("final_count", bus.count, 0);

        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
